// File: rtl/acc_cpu_pkg.sv
// Shared opcode and sequencer-state definitions for the accumulator CPU.
package acc_cpu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_HLT = 3'b000,
    OP_LDA = 3'b001,
    OP_ADD = 3'b010,
    OP_STO = 3'b011,
    OP_SUB = 3'b100,
    OP_JZ  = 3'b101,
    OP_JNC = 3'b110,
    OP_JMP = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_HALT   = 2'b00,
    ST_FETCH  = 2'b01,
    ST_DECODE = 2'b10,
    ST_OPER   = 2'b11
  } state_e;

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational W-bit ALU; bit W of the wide result is carry (ADD) or borrow (SUB).
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int W = 8
) (
  input  opcode_e        op,
  input  logic [W-1:0]   ac,
  input  logic [W-1:0]   operand,
  output logic [W-1:0]   result,
  output logic           cf_next,
  output logic           zf_next
);

  logic [W:0] wide_s;

  // Operation select on a W+1-bit datapath
  always_comb begin
    wide_s = {(W+1){1'b0}};
    case (op)
      OP_ADD:  wide_s = {1'b0, ac} + {1'b0, operand};
      OP_SUB:  wide_s = {1'b0, ac} - {1'b0, operand};
      OP_LDA:  wide_s = {1'b0, operand};
      default: wide_s = {1'b0, ac};
    endcase
  end

  assign result  = wide_s[W-1:0];
  assign cf_next = wide_s[W];
  assign zf_next = (wide_s[W-1:0] == {W{1'b0}});

endmodule

// File: rtl/acc_cpu_core.sv
// Multicycle fetch/decode/execute accumulator CPU with a req/ack memory port.
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int RESET_PC   = 0,
  parameter int AUTO_START = 0,
  parameter int OUT_ADDR   = 7
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [OP_W+ADDR_W-1:0] mem_wdata,
  input  logic [OP_W+ADDR_W-1:0] mem_rdata,
  input  logic                   mem_ack,
  output logic                   out_valid,
  output logic [OP_W+ADDR_W-1:0] out_data,
  output logic                   halted,
  output logic                   instr_done,
  output logic [ADDR_W-1:0]      pc,
  output logic [OP_W+ADDR_W-1:0] ac,
  output logic                   cf,
  output logic                   zf
);

  localparam int W = OP_W + ADDR_W;
  localparam logic [ADDR_W-1:0] RESET_PC_C = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] OUT_ADDR_C = ADDR_W'(OUT_ADDR);
  localparam state_e RESET_ST = (AUTO_START != 0) ? ST_FETCH : ST_HALT;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [W-1:0]       ac_q, ac_d, ir_q, ir_d, out_data_q, out_data_d;
  logic               cf_q, cf_d, zf_q, zf_d;
  logic               out_valid_q, out_valid_d, done_q, done_d;

  opcode_e            op_s;
  logic [ADDR_W-1:0]  addr_s;
  logic [W-1:0]       alu_res_s;
  logic               alu_cf_s, alu_zf_s, busy_s;

  assign op_s   = opcode_e'(ir_q[W-1:ADDR_W]);
  assign addr_s = ir_q[ADDR_W-1:0];

  acc_cpu_alu #(.W(W)) u_alu (
    .op      (op_s),
    .ac      (ac_q),
    .operand (mem_rdata),
    .result  (alu_res_s),
    .cf_next (alu_cf_s),
    .zf_next (alu_zf_s)
  );

  // Request is gated by reset_n so it drops the instant reset is applied
  assign busy_s     = (state_q == ST_FETCH) || (state_q == ST_OPER);
  assign mem_req    = reset_n & busy_s;
  assign mem_we     = reset_n & (state_q == ST_OPER) & (op_s == OP_STO);
  assign mem_addr   = (state_q == ST_OPER) ? addr_s : pc_q;
  assign mem_wdata  = ac_q;
  assign halted     = (state_q == ST_HALT);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign instr_done = done_q;
  assign pc         = pc_q;
  assign ac         = ac_q;
  assign cf         = cf_q;
  assign zf         = zf_q;

  // Sequencer and architectural next-state
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ac_d        = ac_q;
    ir_d        = ir_q;
    cf_d        = cf_q;
    zf_d        = zf_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      ST_HALT: begin
        if (start) state_d = ST_FETCH;
        else       state_d = ST_HALT;
      end
      ST_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (op_s)
          OP_HLT: begin
            done_d  = 1'b1;
            state_d = ST_HALT;
          end
          OP_JZ, OP_JNC, OP_JMP: begin
            if ((op_s == OP_JMP) || ((op_s == OP_JZ) && zf_q) || ((op_s == OP_JNC) && !cf_q))
              pc_d = addr_s;
            else
              pc_d = pc_q;
            done_d  = 1'b1;
            state_d = ST_FETCH;
          end
          default: state_d = ST_OPER;
        endcase
      end
      ST_OPER: begin
        if (mem_ack) begin
          case (op_s)
            OP_LDA: begin
              ac_d = alu_res_s;
              zf_d = alu_zf_s;
            end
            OP_ADD, OP_SUB: begin
              ac_d = alu_res_s;
              cf_d = alu_cf_s;
              zf_d = alu_zf_s;
            end
            OP_STO: begin
              if (addr_s == OUT_ADDR_C) begin
                out_valid_d = 1'b1;
                out_data_d  = ac_q;
              end else begin
                out_valid_d = 1'b0;
              end
            end
            default: ac_d = ac_q;
          endcase
          done_d  = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_OPER;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  // State and register update
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RESET_ST;
      pc_q        <= RESET_PC_C;
      ac_q        <= {W{1'b0}};
      ir_q        <= {W{1'b0}};
      cf_q        <= 1'b0;
      zf_q        <= 1'b0;
      out_data_q  <= {W{1'b0}};
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ac_q        <= ac_d;
      ir_q        <= ir_d;
      cf_q        <= cf_d;
      zf_q        <= zf_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed bench: small program segments separated by HLT, checked at each halt.
module tb_acc_cpu_core;

  logic       clock, reset_n, start;
  logic       mem_req, mem_we, mem_ack;
  logic [4:0] mem_addr, pc;
  logic [7:0] mem_wdata, mem_rdata, out_data, ac;
  logic       out_valid, halted, instr_done, cf, zf;

  logic [7:0] mem  [32];
  logic [7:0] prog [32];
  logic       load, delay_en, slow_s;
  logic [2:0] wait_cnt;
  int         n_checks = 0;
  int         n_fail = 0;
  int         ov_cnt = 0;
  int         n, dones;

  acc_cpu_core #(.ADDR_W(5), .RESET_PC(0), .AUTO_START(0), .OUT_ADDR(7)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .out_valid(out_valid), .out_data(out_data), .halted(halted),
    .instr_done(instr_done), .pc(pc), .ac(ac), .cf(cf), .zf(zf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Data region 24..30 acks after three wait cycles when delay_en is set
  assign slow_s    = delay_en && (mem_addr >= 5'd24) && (mem_addr <= 5'd30);
  assign mem_ack   = mem_req && (!slow_s || (wait_cnt == 3'd3));
  assign mem_rdata = mem[mem_addr];

  always @(posedge clock) begin
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 3'd1;
    else                     wait_cnt <= 3'd0;
    if (load) begin
      for (int i = 0; i < 32; i++) mem[i] <= prog[i];
    end else if (mem_req && mem_ack && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  always @(negedge clock) begin
    if (out_valid) ov_cnt <= ov_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic run_to_halt();
    for (int k = 0; k < 300; k++) begin
      if (halted) break;
      @(negedge clock);
    end
    chk("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) prog[i] = 8'h00;
    prog[0]  = 8'h38; // LDA 24
    prog[1]  = 8'h99; // SUB 25
    prog[2]  = 8'h00; // HLT
    prog[3]  = 8'h99; // SUB 25
    prog[4]  = 8'h99; // SUB 25
    prog[5]  = 8'h99; // SUB 25
    prog[6]  = 8'hE8; // JMP 8
    prog[8]  = 8'hCA; // JNC 10
    prog[9]  = 8'h00; // HLT
    prog[10] = 8'h3A; // LDA 26
    prog[11] = 8'h5B; // ADD 27
    prog[12] = 8'h00; // HLT
    prog[13] = 8'h3C; // LDA 28
    prog[14] = 8'hB1; // JZ 17
    prog[17] = 8'h00; // HLT
    prog[18] = 8'h3D; // LDA 29
    prog[19] = 8'h67; // STO 7
    prog[20] = 8'hFF; // JMP 31
    prog[24] = 8'd15;
    prog[25] = 8'd4;
    prog[26] = 8'd200;
    prog[27] = 8'd100;
    prog[28] = 8'd0;
    prog[29] = 8'h2A;
    prog[31] = 8'h3A; // LDA 26
    reset_n = 1'b0; start = 1'b0; delay_en = 1'b0; load = 1'b1;
    repeat (3) @(negedge clock);
    load = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);

    chk("rst_halted", {31'd0, halted}, 32'd1);
    chk("rst_pc", {27'd0, pc}, 32'd0);
    chk("rst_ac", {24'd0, ac}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_flags", {29'd0, cf, zf, out_valid}, 32'd0);

    // Segment A: zero-wait latency, LDA 15 then SUB 4
    start = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      start = 1'b0;
      n++;
      if (n == 1) begin
        chk("start_req", {31'd0, mem_req}, 32'd1);
        chk("start_addr", {27'd0, mem_addr}, 32'd0);
      end
    end while (!instr_done && n < 50);
    chk("lat_zero_wait", n, 32'd4);
    run_to_halt();
    chk("A_ac", {24'd0, ac}, 32'd11);
    chk("A_cf_zf", {30'd0, cf, zf}, 32'd0);
    chk("A_pc", {27'd0, pc}, 32'd3);

    // Segment B: borrow to 255, JMP over data, JNC not taken
    pulse_start();
    run_to_halt();
    chk("B_ac", {24'd0, ac}, 32'd255);
    chk("B_cf_zf", {30'd0, cf, zf}, 32'd2);
    chk("B_pc", {27'd0, pc}, 32'd10);

    // Segment C: three-wait OPER, then 200+100 carry
    delay_en = 1'b1;
    start = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      start = 1'b0;
      n++;
      if (n >= 3 && n <= 6) begin
        chk("hold_req", {31'd0, mem_req}, 32'd1);
        chk("hold_addr", {27'd0, mem_addr}, 32'd26);
        chk("hold_we", {31'd0, mem_we}, 32'd0);
        chk("hold_wdata", {24'd0, mem_wdata}, 32'd255);
      end
    end while (!instr_done && n < 50);
    chk("lat_three_wait", n, 32'd7);
    chk("C_lda_ac", {24'd0, ac}, 32'd200);
    run_to_halt();
    delay_en = 1'b0;
    chk("C_ac", {24'd0, ac}, 32'd44);
    chk("C_cf_zf", {30'd0, cf, zf}, 32'd2);
    chk("C_pc", {27'd0, pc}, 32'd13);

    // Segment D: LDA 0 sets ZF, JZ taken
    pulse_start();
    run_to_halt();
    chk("D_ac", {24'd0, ac}, 32'd0);
    chk("D_cf_zf", {30'd0, cf, zf}, 32'd3);
    chk("D_pc", {27'd0, pc}, 32'd18);

    // Segment E: STO to output port, JMP 31, PC wrap
    pulse_start();
    dones = 0;
    for (int k = 0; k < 100 && dones < 4; k++) begin
      if (instr_done) dones++;
      if (dones < 4) @(negedge clock);
    end
    chk("E_dones", dones, 32'd4);
    chk("wrap_pc", {27'd0, pc}, 32'd0);
    chk("wrap_req", {31'd0, mem_req}, 32'd1);
    chk("wrap_addr", {27'd0, mem_addr}, 32'd0);
    chk("wrap_ac", {24'd0, ac}, 32'd200);
    chk("out_pulses", ov_cnt, 32'd1);
    chk("out_data", {24'd0, out_data}, 32'h2A);
    chk("sto_mem7", {24'd0, mem[7]}, 32'h2A);
    run_to_halt();
    chk("E_ac", {24'd0, ac}, 32'd11);
    chk("E_pc", {27'd0, pc}, 32'd3);

    // Segment F: reset during an OPER wait
    delay_en = 1'b1;
    pulse_start();
    n = 0;
    while (!(mem_req && mem_addr == 5'd25) && n < 50) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, mem_req}, 32'd0);
    chk("arst_ac", {24'd0, ac}, 32'd0);
    chk("arst_pc", {27'd0, pc}, 32'd0);
    chk("arst_halted", {31'd0, halted}, 32'd1);
    chk("arst_pulses", {30'd0, out_valid, instr_done}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    delay_en = 1'b0;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (mem_req) n++;
    end
    chk("idle_no_req", n, 32'd0);
    chk("idle_ov_cnt", ov_cnt, 32'd1);
    pulse_start();
    run_to_halt();
    chk("F_ac", {24'd0, ac}, 32'd11);
    chk("F_pc", {27'd0, pc}, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
